hm01b0_pixel_ingester: RTL and testbench

- Receives the 8-bit parallel pixel stream of an HM01B0 camera: pixclk, data, hsync (line valid) and vsync (frame valid).
- Re-times the stream into the system clock domain.
- Scatters each pixel into a bank of 512x8 block RAMs, so that every group of 8 image rows (a "strip") lands as 8x8 JPEG blocks.
- Toggles a front/back buffer flag per strip so a downstream JPEG encoder can drain one strip while the next fills.

---
 rtl/hm01b0_pixel_ingester.sv | 129 ++++++++++++
 tb/tb_hm01b0_pixel_ingester.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hm01b0_pixel_ingester.sv
// HM01B0 parallel camera ingester: re-times pixclk/hsync/vsync/data into the system clock
// and scatters pixels into eight 512x8 RAMs as 8x8 JPEG blocks, one strip of 8 rows at a time.
module hm01b0_pixel_ingester #(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 320
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hm01b0_pixclk,
    input  logic [7:0] hm01b0_pixdata,
    input  logic       hm01b0_hsync,
    input  logic       hm01b0_vsync,
    output logic [2:0] output_block_select,
    output logic       frontbuffer_select,
    output logic [8:0] output_write_addr,
    output logic [7:0] output_pixval,
    output logic       wren
);
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned CNT_MAX = 511;

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    state_t             state, state_n;
    logic [2:0]         pclk_q, hs_q, vs_q;
    logic [PIX_W-1:0]   data_q1, data_q2;
    logic [CNT_W-1:0]   row, row_n, col, col_n;
    logic               line_any, line_any_n;
    logic               fb_n, wren_n;
    logic [2:0]         sel_n;
    logic [8:0]         addr_n;
    logic [PIX_W-1:0]   pix_n;

    logic pclk_rise, hs_fall, vs_rise, vs_fall, accept, in_range, took_pixel;

    // Two-flop synchronisers plus one history flop per control line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pclk_q  <= '0;
            hs_q    <= '0;
            vs_q    <= '0;
            data_q1 <= '0;
            data_q2 <= '0;
        end else begin
            pclk_q  <= {pclk_q[1:0], hm01b0_pixclk};
            hs_q    <= {hs_q[1:0], hm01b0_hsync};
            vs_q    <= {vs_q[1:0], hm01b0_vsync};
            data_q1 <= hm01b0_pixdata;
            data_q2 <= data_q1;
        end
    end

    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign hs_fall   = ~hs_q[1] & hs_q[2];
    assign vs_rise   = vs_q[1] & ~vs_q[2];
    assign vs_fall   = ~vs_q[1] & vs_q[2];
    // A pixel edge coinciding with the hsync fall still belongs to the ending line
    assign accept    = pclk_rise & (hs_q[1] | hs_fall) & vs_q[1] & (state == ST_FRAME);
    assign in_range  = (32'(col) < IMAGE_WIDTH) && (32'(row) < IMAGE_HEIGHT);

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        line_any_n = line_any;
        fb_n       = frontbuffer_select;
        wren_n     = 1'b0;
        sel_n      = output_block_select;
        addr_n     = output_write_addr;
        pix_n      = output_pixval;
        took_pixel = line_any;
        if (vs_rise) begin
            state_n    = ST_FRAME;
            row_n      = '0;
            col_n      = '0;
            line_any_n = 1'b0;
            fb_n       = 1'b0;
        end else if (vs_fall) begin
            state_n    = ST_IDLE;
            col_n      = '0;
            line_any_n = 1'b0;
        end else if (state == ST_FRAME) begin
            if (accept) begin
                if (in_range) begin
                    wren_n = 1'b1;
                    sel_n  = col[8:6];
                    addr_n = {col[5:3], row[2:0], col[2:0]};
                    pix_n  = data_q2;
                end
                col_n      = (32'(col) == CNT_MAX) ? col : col + CNT_W'(1);
                line_any_n = 1'b1;
                took_pixel = 1'b1;
            end
            if (hs_fall) begin
                col_n      = '0;
                line_any_n = 1'b0;
                if (took_pixel && (32'(row) != CNT_MAX)) begin
                    row_n = row + CNT_W'(1);
                    if (row[2:0] == 3'd7) fb_n = ~frontbuffer_select;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= ST_IDLE;
            row                 <= '0;
            col                 <= '0;
            line_any            <= 1'b0;
            frontbuffer_select  <= 1'b0;
            wren                <= 1'b0;
            output_block_select <= '0;
            output_write_addr   <= '0;
            output_pixval       <= '0;
        end else begin
            state               <= state_n;
            row                 <= row_n;
            col                 <= col_n;
            line_any            <= line_any_n;
            frontbuffer_select  <= fb_n;
            wren                <= wren_n;
            output_block_select <= sel_n;
            output_write_addr   <= addr_n;
            output_pixval       <= pix_n;
        end
    end
endmodule

// File: tb/tb_hm01b0_pixel_ingester.sv
// Directed bench for hm01b0_pixel_ingester: drives camera lines and checks captured writes.
module tb_hm01b0_pixel_ingester;
    logic       clock = 1'b0;
    logic       reset;
    logic       pixclk, hsync, vsync;
    logic [7:0] pixdata;
    logic [2:0] output_block_select;
    logic       frontbuffer_select;
    logic [8:0] output_write_addr;
    logic [7:0] output_pixval;
    logic       wren;

    int total = 0;
    int bad   = 0;
    int w_sel[$], w_addr[$], w_val[$], w_fb[$];
    logic [7:0] ram [0:1][0:511];
    int  dbl = 0;
    logic wren_prev = 1'b0;

    hm01b0_pixel_ingester #(.IMAGE_WIDTH(320), .IMAGE_HEIGHT(320)) dut (
        .clock(clock), .reset(reset),
        .hm01b0_pixclk(pixclk), .hm01b0_pixdata(pixdata),
        .hm01b0_hsync(hsync), .hm01b0_vsync(vsync),
        .output_block_select(output_block_select), .frontbuffer_select(frontbuffer_select),
        .output_write_addr(output_write_addr), .output_pixval(output_pixval), .wren(wren)
    );

    always #5 clock = ~clock;

    // Write capture, sampled on the falling edge
    always @(negedge clock) begin
        if (!reset && wren) begin
            if (wren_prev) dbl++;
            w_sel.push_back(int'(output_block_select));
            w_addr.push_back(int'(output_write_addr));
            w_val.push_back(int'(output_pixval));
            w_fb.push_back(int'(frontbuffer_select));
            if (output_block_select < 3'd2) ram[output_block_select[0]][output_write_addr] = output_pixval;
        end
        wren_prev = wren;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        w_sel.delete(); w_addr.delete(); w_val.delete(); w_fb.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_pixel(input logic [7:0] v);
        pixclk = 1'b0; pixdata = v; wait_clk(4);
        pixclk = 1'b1; wait_clk(4);
    endtask

    // mode 0: col mod 256; mode 1: checkerboard on (col+row)
    task automatic send_line(input int n, input int row, input int mode);
        hsync = 1'b1; wait_clk(6);
        for (int c = 0; c < n; c++)
            send_pixel(mode == 0 ? 8'(c) : (((c + row) & 1) != 0 ? 8'hFF : 8'h00));
        hsync = 1'b0; wait_clk(8);
    endtask

    task automatic new_frame();
        vsync = 1'b0; wait_clk(8);
        vsync = 1'b1; wait_clk(10);
    endtask

    initial begin
        int errs, exp, lat, base;
        reset = 1'b1; pixclk = 1'b0; hsync = 1'b0; vsync = 1'b0; pixdata = '0;
        wait_clk(5);
        check("rst_wren", int'(wren), 0);
        check("rst_addr", int'(output_write_addr), 0);
        check("rst_pix", int'(output_pixval), 0);
        check("rst_sel", int'(output_block_select), 0);
        check("rst_fb", int'(frontbuffer_select), 0);
        reset = 1'b0;
        wait_clk(100);
        check("idle_writes", w_sel.size(), 0);
        check("idle_addr", int'(output_write_addr), 0);

        // Row 0 ramp line
        new_frame(); clr();
        send_line(320, 0, 0);
        check("ramp_count", w_sel.size(), 320);
        check("p0_sel", w_sel[0], 0);   check("p0_addr", w_addr[0], 0);   check("p0_val", w_val[0], 0);
        check("p9_sel", w_sel[9], 0);   check("p9_addr", w_addr[9], 65);  check("p9_val", w_val[9], 9);
        check("p70_sel", w_sel[70], 1); check("p70_addr", w_addr[70], 6);
        check("p319_sel", w_sel[319], 4); check("p319_addr", w_addr[319], 455);
        check("p319_val", w_val[319], 63);

        // Checkerboard strip in a fresh frame
        new_frame(); clr();
        for (int b = 0; b < 2; b++) for (int a = 0; a < 512; a++) ram[b][a] = 8'h5C;
        for (int r = 0; r < 8; r++) begin
            send_line(128, r, 1);
            if (r == 6) check("fb_before_strip", int'(frontbuffer_select), 0);
        end
        check("fb_after_strip", int'(frontbuffer_select), 1);
        check("cb_count", w_sel.size(), 1024);
        check("cb_fb_during", w_fb[1023], 0);
        for (int m = 0; m < 2; m++) begin
            errs = 0;
            for (int b = 0; b < 8; b++) for (int r = 0; r < 8; r++) for (int x = 0; x < 8; x++) begin
                exp = (((m * 64 + b * 8 + x + r) & 1) != 0) ? 255 : 0;
                if (int'(ram[m][b * 64 + r * 8 + x]) != exp) errs++;
            end
            check(m == 0 ? "ram0_cells_bad" : "ram1_cells_bad", errs, 0);
        end

        // Row 8: over-wide line is clipped at 320
        clr();
        send_line(324, 8, 0);
        check("wide_count", w_sel.size(), 320);
        check("wide_first_addr", w_addr[0], 0);
        check("wide_first_fb", w_fb[0], 1);
        check("wide_last_sel", w_sel[w_sel.size() - 1], 4);
        check("wide_last_addr", w_addr[w_addr.size() - 1], 455);
        check("wide_last_val", w_val[w_val.size() - 1], 63);

        // Rows 9..12, then restart the frame
        clr();
        for (int r = 9; r < 13; r++) send_line(8, r, 0);
        check("short_count", w_sel.size(), 32);
        check("row12_last_addr", w_addr[31], 39);
        check("fb_mid_strip", int'(frontbuffer_select), 1);
        new_frame();
        check("fb_new_frame", int'(frontbuffer_select), 0);
        clr();
        hsync = 1'b1; wait_clk(6);
        pixclk = 1'b0; pixdata = 8'h5A; wait_clk(4);
        pixclk = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(posedge clock); #1;
            if (wren) lat = i;
        end
        check("latency_ok", int'(lat >= 1 && lat <= 4), 1);
        wait_clk(4);
        hsync = 1'b0; wait_clk(8);
        check("nf_count", w_sel.size(), 1);
        check("nf_sel", w_sel[0], 0); check("nf_addr", w_addr[0], 0); check("nf_val", w_val[0], 90);

        // Reset in the middle of row 1
        clr();
        hsync = 1'b1; wait_clk(6);
        for (int c = 0; c < 3; c++) send_pixel(8'(c + 1));
        check("pre_rst_count", w_sel.size(), 3);
        check("pre_rst_addr", w_addr[0], 8);
        base = w_sel.size();
        pixclk = 1'b0; pixdata = 8'h77; wait_clk(4);
        pixclk = 1'b1; wait_clk(1);
        reset = 1'b1;
        wait_clk(5);
        pixclk = 1'b0; hsync = 1'b0; vsync = 1'b0;
        reset = 1'b0;
        wait_clk(50);
        check("rst_mid_stray", w_sel.size(), base);
        check("rst_mid_addr", int'(output_write_addr), 0);
        check("rst_mid_pix", int'(output_pixval), 0);
        clr();
        vsync = 1'b1; wait_clk(10);
        hsync = 1'b1; wait_clk(6);
        send_pixel(8'h11); send_pixel(8'h22);
        hsync = 1'b0; wait_clk(8);
        check("fresh_count", w_sel.size(), 2);
        if (w_sel.size() == 2) begin
            check("fresh_addr0", w_addr[0], 0); check("fresh_val0", w_val[0], 17);
            check("fresh_addr1", w_addr[1], 1); check("fresh_val1", w_val[1], 34);
            check("fresh_sel", w_sel[1], 0);
        end
        check("double_strobes", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
